// File: rtl/wait_state_decoder.sv
// Registered CPU address decoder: one-hot region selects, per-region wait states,
// ready handshake, bus error on unmapped access with fault address/count capture.
module wait_state_decoder #(
    parameter int unsigned ADDRESS_WIDTH = 20,
    parameter int unsigned SELECT_LSB    = 16,
    parameter int unsigned SELECT_BITS   = 3,
    parameter logic [(1<<SELECT_BITS)-1:0]   REGION_MASK = 8'h7f,
    parameter logic [4*(1<<SELECT_BITS)-1:0] WAIT_STATES = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDRESS_WIDTH-1:0]     cpu_address,
    input  logic                         cpu_mem_valid,
    input  logic [3:0]                   cpu_wstrb,
    output logic [(1<<SELECT_BITS)-1:0]  region_en,
    output logic [(1<<SELECT_BITS)-1:0]  region_write_en,
    output logic                         cpu_mem_ready,
    output logic                         bus_error,
    output logic [ADDRESS_WIDTH-1:0]     error_address,
    output logic [7:0]                   error_count,
    output logic                         busy
);

    localparam int unsigned REGIONS = 1 << SELECT_BITS;
    localparam int unsigned HI_LSB  = SELECT_LSB + SELECT_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_FAULT} state_t;

    state_t                 state;
    logic [3:0]             counter;
    logic [SELECT_BITS-1:0] sel_in;
    logic                   high_set;
    logic                   unmapped;
    logic [3:0]             ws_in;
    logic [REGIONS-1:0]     onehot_in;

    assign sel_in = cpu_address[HI_LSB-1:SELECT_LSB];

    // Address bits above the select field must be zero for a mapped access.
    generate
        if (ADDRESS_WIDTH > HI_LSB) begin : g_high_check
            assign high_set = |cpu_address[ADDRESS_WIDTH-1:HI_LSB];
        end else begin : g_no_high_check
            assign high_set = 1'b0;
        end
    endgenerate

    assign unmapped  = !REGION_MASK[sel_in] || high_set;
    assign ws_in     = WAIT_STATES[{sel_in, 2'b00} +: 4];
    assign onehot_in = {{(REGIONS-1){1'b0}}, 1'b1} << sel_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            counter         <= '0;
            region_en       <= '0;
            region_write_en <= '0;
            cpu_mem_ready   <= 1'b0;
            bus_error       <= 1'b0;
            error_address   <= '0;
            error_count     <= '0;
            busy            <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_mem_valid) begin
                        busy <= 1'b1;
                        if (unmapped) begin
                            state         <= S_FAULT;
                            cpu_mem_ready <= 1'b1;
                            bus_error     <= 1'b1;
                            error_address <= cpu_address;
                            if (error_count != 8'hff) begin
                                error_count <= error_count + 8'd1;
                            end
                        end else begin
                            region_en       <= onehot_in;
                            region_write_en <= (|cpu_wstrb) ? onehot_in : '0;
                            if (ws_in == 4'd0) begin
                                state         <= S_ACK;
                                cpu_mem_ready <= 1'b1;
                            end else begin
                                state   <= S_WAIT;
                                counter <= ws_in;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (!cpu_mem_valid) begin
                        state           <= S_IDLE;
                        counter         <= '0;
                        region_en       <= '0;
                        region_write_en <= '0;
                        busy            <= 1'b0;
                    end else if (counter == 4'd1) begin
                        state         <= S_ACK;
                        counter       <= '0;
                        cpu_mem_ready <= 1'b1;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                S_ACK, S_FAULT: begin
                    state           <= S_IDLE;
                    region_en       <= '0;
                    region_write_en <= '0;
                    cpu_mem_ready   <= 1'b0;
                    bus_error       <= 1'b0;
                    busy            <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wait_state_decoder.sv
// Self-checking bench for wait_state_decoder: directed scenarios plus randomized
// transactions checked cycle by cycle against a per-transaction timeline model.
module tb_wait_state_decoder;

    localparam logic [7:0]  MASK = 8'h7f;
    localparam logic [31:0] WS   = 32'h0731_F520;

    int ws_tab [8]     = '{0, 2, 5, 15, 1, 3, 7, 0};
    bit mapped_tab [8] = '{1, 1, 1, 1, 1, 1, 1, 0};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] cpu_address = '0;
    logic        cpu_mem_valid = 1'b0;
    logic [3:0]  cpu_wstrb = '0;
    logic [7:0]  region_en;
    logic [7:0]  region_write_en;
    logic        cpu_mem_ready;
    logic        bus_error;
    logic [19:0] error_address;
    logic [7:0]  error_count;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [19:0] m_err_addr = '0;
    int          m_err_count = 0;

    wait_state_decoder #(
        .ADDRESS_WIDTH(20),
        .SELECT_LSB   (16),
        .SELECT_BITS  (3),
        .REGION_MASK  (MASK),
        .WAIT_STATES  (WS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_address    (cpu_address),
        .cpu_mem_valid  (cpu_mem_valid),
        .cpu_wstrb      (cpu_wstrb),
        .region_en      (region_en),
        .region_write_en(region_write_en),
        .cpu_mem_ready  (cpu_mem_ready),
        .bus_error      (bus_error),
        .error_address  (error_address),
        .error_count    (error_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Called at a negedge. Presents one request, then checks every cycle through the
    // IDLE turnaround; abort_at > 0 drops valid during that WAIT cycle.
    task automatic run_txn(input string name, input logic [19:0] addr, input logic [3:0] strb,
                           input int abort_at, input bit keep_valid);
        int   sel, w, last;
        bit   fault;
        logic [7:0] e_en, e_wen;
        logic e_rdy, e_err, e_busy;
        sel   = int'(addr[18:16]);
        w     = ws_tab[sel];
        fault = !mapped_tab[sel] || addr[19];
        last  = fault ? 1 : ((abort_at > 0) ? abort_at : w + 1);
        cpu_address   = addr;
        cpu_wstrb     = strb;
        cpu_mem_valid = 1'b1;
        @(posedge clk);
        if (fault) begin
            m_err_addr = addr;
            if (m_err_count < 255) m_err_count++;
        end
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            e_en = '0; e_wen = '0; e_rdy = 1'b0; e_err = 1'b0; e_busy = 1'b0;
            if (c <= last) begin
                e_busy = 1'b1;
                if (fault) begin
                    e_rdy = 1'b1;
                    e_err = 1'b1;
                end else begin
                    e_en  = 8'h01 << sel;
                    e_wen = (strb != 4'h0) ? e_en : 8'h00;
                    e_rdy = (abort_at == 0) && (c == w + 1);
                end
            end
            checks++;
            if (region_en !== e_en) begin
                errors++;
                $display("FAIL %s c%0d region_en got %h want %h", name, c, region_en, e_en);
            end
            checks++;
            if (region_write_en !== e_wen) begin
                errors++;
                $display("FAIL %s c%0d region_write_en got %h want %h", name, c, region_write_en, e_wen);
            end
            checks++;
            if (cpu_mem_ready !== e_rdy) begin
                errors++;
                $display("FAIL %s c%0d cpu_mem_ready got %b want %b", name, c, cpu_mem_ready, e_rdy);
            end
            checks++;
            if (bus_error !== e_err) begin
                errors++;
                $display("FAIL %s c%0d bus_error got %b want %b", name, c, bus_error, e_err);
            end
            checks++;
            if (busy !== e_busy) begin
                errors++;
                $display("FAIL %s c%0d busy got %b want %b", name, c, busy, e_busy);
            end
            checks++;
            if (error_address !== m_err_addr) begin
                errors++;
                $display("FAIL %s c%0d error_address got %h want %h", name, c, error_address, m_err_addr);
            end
            checks++;
            if (error_count !== 8'(m_err_count)) begin
                errors++;
                $display("FAIL %s c%0d error_count got %0d want %0d", name, c, error_count, m_err_count);
            end
            if (c <= last) begin
                cpu_address = 20'($urandom);
                cpu_wstrb   = 4'($urandom);
            end
            if (c == abort_at) cpu_mem_valid = 1'b0;
            if (c == last + 1) cpu_mem_valid = keep_valid;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({region_en, region_write_en, cpu_mem_ready, bus_error, busy, error_address, error_count} !== '0) begin
            errors++;
            $display("FAIL reset outputs got en=%h wen=%h rdy=%b err=%b busy=%b ea=%h ec=%0d want all 0",
                     region_en, region_write_en, cpu_mem_ready, bus_error, busy, error_address, error_count);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cpu_mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL post_reset busy=%b rdy=%b want 0 0", busy, cpu_mem_ready);
        end
    endtask

    task automatic test_region0_read();
        run_txn("r0_read", 20'h00010, 4'h0, 0, 1'b1);
        run_txn("r0_b2b", 20'h00010, 4'h0, 0, 1'b0);
    endtask

    task automatic test_write_wait();
        run_txn("r1_write", 20'h10004, 4'hf, 0, 1'b0);
    endtask

    task automatic test_masked_fault();
        run_txn("masked", 20'h70000, 4'h0, 0, 1'b0);
        checks++;
        if (error_count !== 8'd1 || error_address !== 20'h70000) begin
            errors++;
            $display("FAIL masked_capture got ec=%0d ea=%h want 1 70000", error_count, error_address);
        end
    endtask

    task automatic test_high_bit_fault();
        run_txn("high_bit", 20'h80000, 4'h3, 0, 1'b0);
    endtask

    task automatic test_abort();
        run_txn("abort", 20'h10000, 4'h1, 1, 1'b0);
    endtask

    task automatic test_max_wait();
        run_txn("max_wait", 20'h30020, 4'h0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_a", 20'h20000, 4'h2, 0, 1'b1);
        run_txn("b2b_b", 20'h71234, 4'h0, 0, 1'b1);
        run_txn("b2b_c", 20'h40008, 4'h8, 0, 1'b1);
        run_txn("b2b_d", 20'h60000, 4'h0, 3, 1'b1);
        run_txn("b2b_e", 20'h00000, 4'h0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            logic [19:0] a;
            logic [3:0]  s;
            int          ab, w;
            a  = {($urandom_range(0, 7) == 0), 19'($urandom)};
            s  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            w  = ws_tab[int'(a[18:16])];
            ab = 0;
            if (w > 0 && !a[19] && $urandom_range(0, 3) == 0) ab = $urandom_range(1, w);
            run_txn("random", a, s, ab, 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_wait();
        cpu_address   = 20'h30000;
        cpu_wstrb     = 4'hf;
        cpu_mem_valid = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({region_en, region_write_en, cpu_mem_ready, bus_error, busy, error_address, error_count} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait got en=%h wen=%h rdy=%b err=%b busy=%b ea=%h ec=%0d want all 0",
                     region_en, region_write_en, cpu_mem_ready, bus_error, busy, error_address, error_count);
        end
        cpu_mem_valid = 1'b0;
        m_err_addr    = '0;
        m_err_count   = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cpu_mem_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_suppress rdy=%b busy=%b want 0 0", cpu_mem_ready, busy);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 258; i++) begin
            run_txn("saturate", {4'h7, 16'($urandom)}, 4'h0, 0, 1'b1);
        end
        run_txn("sat_addr", 20'h8abcd, 4'h0, 0, 1'b0);
        checks++;
        if (error_count !== 8'd255 || error_address !== 20'h8abcd) begin
            errors++;
            $display("FAIL saturation got ec=%0d ea=%h want 255 8abcd", error_count, error_address);
        end
    endtask

    initial begin
        test_reset();
        test_region0_read();
        test_write_wait();
        test_masked_fault();
        test_high_bit_fault();
        test_abort();
        test_max_wait();
        test_back_to_back();
        test_random();
        test_reset_mid_wait();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wait_state_decoder.md
# wait_state_decoder

Parametrised, registered CPU address decoder generating one-hot region enables, per-region wait states and the CPU `cpu_mem_ready` handshake. It replaces the fixed 8-way combinational decode between the CPU bus and the peripheral/RAM selects. It adds three things:
- unmapped-region detection with a bus error and captured fault address;
- programmable latency per region;
- clean abort handling when `cpu_mem_valid` drops mid-transaction.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 20: CPU address width.
- `SELECT_LSB`, 16: lowest address bit of the region select field.
- `SELECT_BITS`, 3: width of the select field. Derived `REGIONS = 1 << SELECT_BITS`.
- `REGION_MASK`, `8'h7f`: bit i = 1 means region i is mapped. Width `REGIONS`.
- `WAIT_STATES`, 0: packed, 4 bits per region, with region i at `[4*i+3:4*i]`. Width `4*REGIONS`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `cpu_address` in `ADDRESS_WIDTH`: byte address.
- `cpu_mem_valid` in 1: request valid. Held by the CPU until ready.
- `cpu_wstrb` in 4: write strobes. Nonzero means write.
- `region_en` out `REGIONS`: one-hot select of the active region.
- `region_write_en` out `REGIONS`: `region_en` qualified by a nonzero latched `cpu_wstrb`.
- `cpu_mem_ready` out 1: one-cycle transaction-complete pulse.
- `bus_error` out 1: asserted coincident with `cpu_mem_ready` for a faulting access.
- `error_address` out `ADDRESS_WIDTH`: address of the most recent fault.
- `error_count` out 8: number of faults, saturating at 255.
- `busy` out 1: state is not IDLE.

## Operation
States: IDLE, WAIT, ACK, FAULT.

- **IDLE:**
  - On a clock edge with `cpu_mem_valid` = 1, latch the region index `sel = cpu_address[SELECT_LSB+SELECT_BITS-1:SELECT_LSB]` and whether `cpu_wstrb` is nonzero.
  - The access is unmapped if `REGION_MASK[sel]` = 0, or if any address bit above the select field is 1. The high-bit check is omitted when no such bits exist.
  - Unmapped: go to FAULT. Latch `error_address` and increment `error_count` unless it is already 255.
  - Mapped, `WAIT_STATES[sel]` = 0: go to ACK.
  - Mapped, `WAIT_STATES[sel]` nonzero: go to WAIT with counter = `WAIT_STATES[sel]`.
- **WAIT:**
  - Counter decrements each cycle. When it reaches 1, the next state is ACK.
  - `cpu_mem_valid` = 0 in WAIT is an abort: go to IDLE with no ready and no error.
- **ACK:** `cpu_mem_ready` = 1. Next state is IDLE unconditionally.
- **FAULT:** `cpu_mem_ready` = 1 and `bus_error` = 1, for one cycle only. Next state is IDLE.

Outputs:
- All outputs are registered.
- `region_en[sel]` is 1 in WAIT and ACK and 0 elsewhere. `region_write_en` follows the same rule, additionally gated by the latched write flag.
- Enables are never asserted in FAULT or IDLE.
- Address and strobe changes after the IDLE sample are ignored until the next IDLE.

Reset values: state IDLE, counter 0, all enables 0, `cpu_mem_ready` 0, `bus_error` 0, `busy` 0, `error_address` 0, `error_count` 0. Reset mid-transaction drops all outputs immediately (asynchronously) and suppresses the pending ready.

## Timing
- Valid is sampled at edge k with wait states W.
  - `region_en` is high in cycles k+1 … k+W+1.
  - `cpu_mem_ready` is high in cycle k+W+1 only.
- Fault: `cpu_mem_ready` and `bus_error` are high in cycle k+1 only.
- The earliest next sample is edge k+W+2 (fault: k+2). There is one IDLE turnaround cycle after every ACK, FAULT or abort, even if valid stays high.
- An abort observed at the edge ending a WAIT cycle lands in IDLE at that edge. Valid is then re-sampled at the following edge.
- With W = 15 (maximum): ready is high in cycle k+16.
- Simultaneous fault and saturated `error_count`: the count holds at 255 and `error_address` still updates.

## Test plan
- Region 0 read, `WAIT_STATES` = 0, address `20'h00010` valid at edge 0:
  - `region_en` = `8'h01` in cycle 1;
  - ready in cycle 1;
  - `region_write_en` = 0;
  - valid held high gives the next ready in cycle 3.
- Region 1 write, `WAIT_STATES[7:4]` = 2, address `20'h10004`, `cpu_wstrb` = `4'hf`:
  - `region_en` = `region_write_en` = `8'h02` in cycles 1–3;
  - ready in cycle 3 only.
- Access to region 7 (masked), address `20'h70000`:
  - no enables;
  - ready = `bus_error` = 1 in cycle 1;
  - `error_address` = `20'h70000`;
  - `error_count` = 1.
- High-bit fault at address `20'h80000` (select = 0, bit 19 set):
  - bus error;
  - `error_count` increments;
  - region 0 is never enabled.
- Region 1 with W = 2: drop valid in cycle 1:
  - enables low from cycle 2;
  - no ready;
  - `busy` = 0 in cycle 2.
- Assert reset during WAIT:
  - all outputs 0 immediately;
  - 256 subsequent faults leave `error_count` = 255.
